// File: rtl/sdp_wdma_pkg.sv
// Shared types and pd-bus layout for the SDP write-DMA command generator.
package sdp_wdma_pkg;
  localparam int AW = 59;
  localparam int SW = 27;
  localparam int CW = 13;

  localparam int DMA_PD_W     = 74;
  localparam int DMA_ADDR_LSB = 0;
  localparam int DMA_SIZE_LSB = 59;
  localparam int DMA_ODD_BIT  = 72;
  localparam int DMA_END_BIT  = 73;

  localparam int SPT_PD_W     = 15;
  localparam int SPT_SIZE_LSB = 0;
  localparam int SPT_ODD_BIT  = 13;
  localparam int SPT_END_BIT  = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [CW-1:0] size;
    logic          odd;
    logic          cube_end;
  } cmd_t;

  function automatic logic [DMA_PD_W-1:0] pack_dma(input cmd_t c);
    logic [DMA_PD_W-1:0] pd;
    pd = '0;
    pd[DMA_ADDR_LSB +: AW] = c.addr;
    pd[DMA_SIZE_LSB +: CW] = c.size;
    pd[DMA_ODD_BIT]        = c.odd;
    pd[DMA_END_BIT]        = c.cube_end;
    return pd;
  endfunction

  function automatic logic [SPT_PD_W-1:0] pack_spt(input cmd_t c);
    logic [SPT_PD_W-1:0] pd;
    pd = '0;
    pd[SPT_SIZE_LSB +: CW] = c.size;
    pd[SPT_ODD_BIT]        = c.odd;
    pd[SPT_END_BIT]        = c.cube_end;
    return pd;
  endfunction
endpackage

// File: rtl/sdp_wdma_cmd_fork.sv
// Two-way valid/ready fork: one upstream command, two consumers, each accepts once.
module sdp_wdma_cmd_fork (
  input  logic clk,
  input  logic rst,
  input  logic in_vld,
  output logic in_rdy,
  output logic a_vld,
  input  logic a_rdy,
  output logic b_vld,
  input  logic b_rdy
);
  logic [1:0] acc;
  logic       a_fire, b_fire;

  assign a_vld  = in_vld & ~acc[0];
  assign b_vld  = in_vld & ~acc[1];
  assign a_fire = a_vld & a_rdy;
  assign b_fire = b_vld & b_rdy;
  // retires when each side has either already accepted or accepts now
  assign in_rdy = (acc[0] | a_fire) & (acc[1] | b_fire);

  always_ff @(posedge clk) begin
    if (rst)                  acc <= 2'b00;
    else if (in_vld & in_rdy) acc <= 2'b00;
    else                      acc <= acc | {b_fire, a_fire};
  end
endmodule

// File: rtl/sdp_wdma_cmd_gen.sv
// Walks the destination cube (surfaces, then lines) and issues one command per line.
// Optional stall counter enabled by SDP_WDMA_CMD_PERF_EN.
module sdp_wdma_cmd_gen
  import sdp_wdma_pkg::*;
(
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rst,
  input  logic                op_load,
  input  logic [AW-1:0]       reg2dp_dst_base_addr,
  input  logic [SW-1:0]       reg2dp_dst_line_stride,
  input  logic [SW-1:0]       reg2dp_dst_surface_stride,
  input  logic [CW-1:0]       reg2dp_width,
  input  logic [CW-1:0]       reg2dp_height,
  input  logic [CW-1:0]       reg2dp_surface_num,
  output logic                cmd2dat_dma_pvld,
  input  logic                cmd2dat_dma_prdy,
  output logic [DMA_PD_W-1:0] cmd2dat_dma_pd,
  output logic                cmd2dat_spt_pvld,
  input  logic                cmd2dat_spt_prdy,
  output logic [SPT_PD_W-1:0] cmd2dat_spt_pd,
  output logic                cmd_busy
`ifdef SDP_WDMA_CMD_PERF_EN
  ,
  output logic [31:0]         dp2reg_wdma_cmd_stall
`endif
);
  state_e        state;
  cmd_t          cmd_q;
  logic [AW-1:0] line_addr, surf_addr;
  logic [SW-1:0] line_stride_q, surf_stride_q;
  logic [CW-1:0] height_q, surf_num_q, line_cnt, surf_cnt;
  logic          issue_vld, fork_rdy, retire;

  logic [AW-1:0] nxt_line_addr, nxt_surf_addr;
  logic [CW-1:0] nxt_line_cnt, nxt_surf_cnt;
  logic          nxt_end;

  assign issue_vld = (state == ST_ISSUE);
  assign retire    = issue_vld & fork_rdy;

  sdp_wdma_cmd_fork u_fork (
    .clk    (nvdla_core_clk),
    .rst    (nvdla_core_rst),
    .in_vld (issue_vld),
    .in_rdy (fork_rdy),
    .a_vld  (cmd2dat_dma_pvld),
    .a_rdy  (cmd2dat_dma_prdy),
    .b_vld  (cmd2dat_spt_pvld),
    .b_rdy  (cmd2dat_spt_prdy)
  );

  assign cmd2dat_dma_pd = pack_dma(cmd_q);
  assign cmd2dat_spt_pd = pack_spt(cmd_q);

  always_comb begin
    nxt_line_cnt  = line_cnt + 13'd1;
    nxt_surf_cnt  = surf_cnt;
    nxt_surf_addr = surf_addr;
    nxt_line_addr = line_addr + {{(AW-SW){1'b0}}, line_stride_q};
    // last line of a surface: next line starts the following surface
    if (line_cnt == height_q) begin
      nxt_line_cnt  = '0;
      nxt_surf_cnt  = surf_cnt + 13'd1;
      nxt_surf_addr = surf_addr + {{(AW-SW){1'b0}}, surf_stride_q};
      nxt_line_addr = nxt_surf_addr;
    end
    nxt_end = (nxt_line_cnt == height_q) && (nxt_surf_cnt == surf_num_q);
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state         <= ST_IDLE;
      cmd_busy      <= 1'b0;
      cmd_q         <= '0;
      line_addr     <= '0;
      surf_addr     <= '0;
      line_cnt      <= '0;
      surf_cnt      <= '0;
      line_stride_q <= '0;
      surf_stride_q <= '0;
      height_q      <= '0;
      surf_num_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (op_load) begin
          state          <= ST_ISSUE;
          cmd_busy       <= 1'b1;
          line_stride_q  <= reg2dp_dst_line_stride;
          surf_stride_q  <= reg2dp_dst_surface_stride;
          height_q       <= reg2dp_height;
          surf_num_q     <= reg2dp_surface_num;
          line_addr      <= reg2dp_dst_base_addr;
          surf_addr      <= reg2dp_dst_base_addr;
          line_cnt       <= '0;
          surf_cnt       <= '0;
          cmd_q.addr     <= reg2dp_dst_base_addr;
          cmd_q.size     <= reg2dp_width;
          cmd_q.odd      <= ~reg2dp_width[0];
          cmd_q.cube_end <= (reg2dp_height == '0) && (reg2dp_surface_num == '0);
        end
        ST_ISSUE: if (retire) begin
          if (cmd_q.cube_end) begin
            state <= ST_DRAIN;
          end else begin
            line_cnt       <= nxt_line_cnt;
            surf_cnt       <= nxt_surf_cnt;
            line_addr      <= nxt_line_addr;
            surf_addr      <= nxt_surf_addr;
            cmd_q.addr     <= nxt_line_addr;
            cmd_q.cube_end <= nxt_end;
          end
        end
        ST_DRAIN: begin
          state    <= ST_IDLE;
          cmd_busy <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SDP_WDMA_CMD_PERF_EN
  logic stall_cyc;
  assign stall_cyc = issue_vld &&
                     ((cmd2dat_dma_pvld && !cmd2dat_dma_prdy) ||
                      (cmd2dat_spt_pvld && !cmd2dat_spt_prdy));

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst)                          dp2reg_wdma_cmd_stall <= '0;
    else if (op_load && state == ST_IDLE)        dp2reg_wdma_cmd_stall <= '0;
    else if (stall_cyc && !(&dp2reg_wdma_cmd_stall))
      dp2reg_wdma_cmd_stall <= dp2reg_wdma_cmd_stall + 32'd1;
  end
`endif
endmodule

// File: tb/tb_sdp_wdma_cmd_gen.sv
// Bench for sdp_wdma_cmd_gen: vector table, hand corner sequences, random cubes vs. a loop model.
module tb_sdp_wdma_cmd_gen;
  logic        clk = 1'b0;
  logic        rst;
  logic        op_load;
  logic [58:0] base;
  logic [26:0] lstride, sstride;
  logic [12:0] width, height, surf_num;
  logic        dma_pvld, dma_prdy, spt_pvld, spt_prdy, cmd_busy;
  logic [73:0] dma_pd;
  logic [14:0] spt_pd;
`ifdef SDP_WDMA_CMD_PERF_EN
  logic [31:0] stall;
`endif

  always #5 clk = ~clk;

  sdp_wdma_cmd_gen dut (
    .nvdla_core_clk            (clk),
    .nvdla_core_rst            (rst),
    .op_load                   (op_load),
    .reg2dp_dst_base_addr      (base),
    .reg2dp_dst_line_stride    (lstride),
    .reg2dp_dst_surface_stride (sstride),
    .reg2dp_width              (width),
    .reg2dp_height             (height),
    .reg2dp_surface_num        (surf_num),
    .cmd2dat_dma_pvld          (dma_pvld),
    .cmd2dat_dma_prdy          (dma_prdy),
    .cmd2dat_dma_pd            (dma_pd),
    .cmd2dat_spt_pvld          (spt_pvld),
    .cmd2dat_spt_prdy          (spt_prdy),
    .cmd2dat_spt_pd            (spt_pd),
    .cmd_busy                  (cmd_busy)
`ifdef SDP_WDMA_CMD_PERF_EN
    ,
    .dp2reg_wdma_cmd_stall     (stall)
`endif
  );

  typedef struct {
    logic [58:0] base;
    logic [26:0] ls, ss;
    logic [12:0] w, h, sn;
    int          exp_n;     // hand-computed command count, -1 = not given
    logic [58:0] exp_last;  // hand-computed address of the final command
  } vec_t;

  typedef struct {
    logic [58:0] addr;
    logic [12:0] size;
    logic        odd;
    logic        ce;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
  endfunction

  // Reference: every (surface, line) pair in order, address from plain multiply-add mod 2^59.
  function automatic void build_exp(input vec_t v);
    exp_t e;
    exp_q.delete();
    for (int s = 0; s <= int'(v.sn); s++)
      for (int l = 0; l <= int'(v.h); l++) begin
        e.addr = v.base + 59'(s) * 59'(v.ss) + 59'(l) * 59'(v.ls);
        e.size = v.w;
        e.odd  = ((int'(v.w) + 1) % 2) == 1;
        e.ce   = (s == int'(v.sn)) && (l == int'(v.h));
        exp_q.push_back(e);
      end
  endfunction

  task automatic program_cfg(input vec_t v);
    base = v.base; lstride = v.ls; sstride = v.ss;
    width = v.w; height = v.h; surf_num = v.sn;
  endtask

  task automatic pulse_load();
    op_load = 1'b1;
    @(posedge clk); #1;
    op_load = 1'b0;
  endtask

  task automatic run_cube(input vec_t v, input int pct, input string tag);
    int dma_i, spt_i, drain, n;
    logic [58:0] last_addr;
    logic [73:0] e_dma;
    logic [14:0] e_spt;
    build_exp(v);
    n = exp_q.size();
    dma_i = 0; spt_i = 0; drain = 0; last_addr = '0;
    chk({tag, ".idle_busy"}, 128'(cmd_busy), 128'(0));
    program_cfg(v);
    pulse_load();
    chk({tag, ".first_vld"}, 128'({dma_pvld, spt_pvld, cmd_busy}), 128'(3'b111));
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!cmd_busy) break;
      if (dma_i >= n && spt_i >= n) drain++;
      dma_prdy = ($urandom_range(99) < pct);
      spt_prdy = ($urandom_range(99) < pct);
      @(negedge clk);
      if (dma_pvld && dma_prdy) begin
        if (dma_i < n) begin
          e_dma = {exp_q[dma_i].ce, exp_q[dma_i].odd, exp_q[dma_i].size, exp_q[dma_i].addr};
          chk({tag, ".dma_pd"}, 128'(dma_pd), 128'(e_dma));
        end
        last_addr = dma_pd[58:0];
        dma_i++;
      end
      if (spt_pvld && spt_prdy) begin
        if (spt_i < n) begin
          e_spt = {exp_q[spt_i].ce, exp_q[spt_i].odd, exp_q[spt_i].size};
          chk({tag, ".spt_pd"}, 128'(spt_pd), 128'(e_spt));
        end
        spt_i++;
      end
      @(posedge clk); #1;
    end
    chk({tag, ".busy_end"}, 128'(cmd_busy), 128'(0));
    chk({tag, ".dma_cnt"}, 128'(dma_i), 128'(n));
    chk({tag, ".spt_cnt"}, 128'(spt_i), 128'(n));
    chk({tag, ".drain_cyc"}, 128'(drain), 128'(1));
    if (v.exp_n >= 0) begin
      chk({tag, ".hand_cnt"}, 128'(dma_i), 128'(v.exp_n));
      chk({tag, ".hand_last"}, 128'(last_addr), 128'(v.exp_last));
    end
  endtask

  vec_t        vecs[5];
  vec_t        r;
  logic [58:0] wrap_base;

  initial begin
    wrap_base = '1;
    wrap_base = wrap_base - 59'd15;  // 2^59 - 0x10
    vecs[0] = '{base: 59'h100, ls: 27'h10, ss: 27'h0,  w: 13'd3, h: 13'd1, sn: 13'd0, exp_n: 2, exp_last: 59'h110};
    vecs[1] = '{base: 59'h5,   ls: 27'h7,  ss: 27'h9,  w: 13'd0, h: 13'd0, sn: 13'd0, exp_n: 1, exp_last: 59'h5};
    vecs[2] = '{base: 59'h0,   ls: 27'h4,  ss: 27'h40, w: 13'd7, h: 13'd1, sn: 13'd1, exp_n: 4, exp_last: 59'h44};
    vecs[3] = '{base: wrap_base, ls: 27'h20, ss: 27'h0, w: 13'd2, h: 13'd1, sn: 13'd0, exp_n: 2, exp_last: 59'h10};
    vecs[4] = '{base: 59'h33,  ls: 27'h0,  ss: 27'h0,  w: 13'd5, h: 13'd2, sn: 13'd1, exp_n: 6, exp_last: 59'h33};

    rst = 1'b1; op_load = 1'b0; dma_prdy = 1'b0; spt_prdy = 1'b0;
    program_cfg(vecs[0]);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset.out", 128'({dma_pvld, spt_pvld, cmd_busy}), 128'(0));
    chk("reset.dma_pd", 128'(dma_pd), 128'(0));
    chk("reset.spt_pd", 128'(spt_pd), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) run_cube(vecs[i], 100, $sformatf("vec%0d", i));

    // One side held off: other side accepts once, the next command waits for both.
    program_cfg(vecs[0]);
    dma_prdy = 1'b1; spt_prdy = 1'b0;
    pulse_load();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.dma_vld", 128'(dma_pvld), 128'(i == 0));
      chk("bp.spt_vld", 128'(spt_pvld), 128'(1));
      chk("bp.addr_hold", 128'(dma_pd[58:0]), 128'(59'h100));
      @(posedge clk); #1;
    end
    spt_prdy = 1'b1;
    @(negedge clk);
    chk("bp.release", 128'({dma_pvld, spt_pvld}), 128'(2'b01));
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp.next_vld", 128'({dma_pvld, spt_pvld}), 128'(2'b11));
    chk("bp.next_pd", 128'(dma_pd), 128'({1'b1, 1'b0, 13'd3, 59'h110}));
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("bp.busy_end", 128'(cmd_busy), 128'(0));
`ifdef SDP_WDMA_CMD_PERF_EN
    chk("bp.stall_cnt", 128'(stall), 128'(5));
`endif

    // Wrap case with a second op_load while issuing: the second load is ignored.
    dma_prdy = 1'b0; spt_prdy = 1'b0;
    program_cfg(vecs[3]);
    pulse_load();
    base = 59'h777; width = 13'd9;
    pulse_load();
    @(negedge clk);
    chk("reload.first", 128'(dma_pd), 128'({1'b0, 1'b1, 13'd2, wrap_base}));
    dma_prdy = 1'b1; spt_prdy = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reload.wrap", 128'(dma_pd), 128'({1'b1, 1'b1, 13'd2, 59'h10}));
    chk("reload.spt", 128'(spt_pd), 128'({1'b1, 1'b1, 13'd2}));
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reload.busy_end", 128'(cmd_busy), 128'(0));

    // Reset while the third command is presented, then a clean restart.
    program_cfg(vecs[2]);
    dma_prdy = 1'b1; spt_prdy = 1'b1;
    pulse_load();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst.third_addr", 128'(dma_pd[58:0]), 128'(59'h40));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst.out", 128'({dma_pvld, spt_pvld, cmd_busy}), 128'(0));
    chk("rst.pd", 128'({dma_pd, spt_pd}), 128'(0));
    run_cube(vecs[2], 100, "rst.restart");

    for (int k = 0; k < 12; k++) begin
      r.base     = 59'({$urandom(), $urandom()});
      r.ls       = ($urandom_range(3) == 0) ? 27'd0 : 27'($urandom());
      r.ss       = ($urandom_range(3) == 0) ? 27'd0 : 27'($urandom());
      r.w        = 13'($urandom());
      r.h        = 13'($urandom_range(3));
      r.sn       = 13'($urandom_range(3));
      r.exp_n    = -1;
      r.exp_last = '0;
      run_cube(r, 60, $sformatf("rand%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
